// File: rtl/ysyx_23060096_cam_pkg.sv
// rtl/ysyx_23060096_cam_pkg.sv - shared types and helpers for the key CAM
// Contents:
//   upd_kind_t : how an update request is placed (hit overwrite, allocate, replace)
//   idx_len()  : entry-index width for a table of nr_key entries (at least 1 bit)
package ysyx_23060096_cam_pkg;

  typedef enum logic [1:0] {
    UPD_HIT,
    UPD_ALLOC,
    UPD_REPLACE
  } upd_kind_t;

  function automatic int idx_len(input int nr_key);
    return $clog2(nr_key > 1 ? nr_key : 2);
  endfunction

endpackage

// File: rtl/ysyx_23060096_prio_enc.sv
// rtl/ysyx_23060096_prio_enc.sv - lowest-set-bit priority encoder
// Ports:
//   req   : request vector, bit i set means candidate i
//   found : any request bit set
//   idx   : index of the lowest set bit, 0 when nothing is set
module ysyx_23060096_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scanning from the top down lets the lowest set bit write last and win.
  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/ysyx_23060096_key_cam.sv
// rtl/ysyx_23060096_key_cam.sv - writable key->data table with registered lookup
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   lk_valid, lk_key, default_out : lookup request, key and miss value
//   lk_resp_valid, lk_hit,
//   lk_idx, lk_data               : registered lookup response, one cycle later
//   upd_en, upd_key, upd_data     : insert or update an entry
//   inv_en, inv_key               : invalidate entries holding inv_key
//   flush                         : invalidate every entry
//   full, count                   : registered occupancy after the edge
module ysyx_23060096_key_cam
  import ysyx_23060096_cam_pkg::*;
#(
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 8,
  parameter int DATA_LEN    = 32,
  parameter int HAS_DEFAULT = 0,
  parameter int IDX_LEN     = idx_len(NR_KEY)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lk_valid,
  input  logic [KEY_LEN-1:0]  lk_key,
  input  logic [DATA_LEN-1:0] default_out,
  output logic                lk_resp_valid,
  output logic                lk_hit,
  output logic [IDX_LEN-1:0]  lk_idx,
  output logic [DATA_LEN-1:0] lk_data,
  input  logic                upd_en,
  input  logic [KEY_LEN-1:0]  upd_key,
  input  logic [DATA_LEN-1:0] upd_data,
  input  logic                inv_en,
  input  logic [KEY_LEN-1:0]  inv_key,
  input  logic                flush,
  output logic                full,
  output logic [IDX_LEN:0]    count
);

  localparam int CNT_W = IDX_LEN + 1;

  logic [NR_KEY-1:0]   valid_q, valid_d;
  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [KEY_LEN-1:0]  key_d  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];
  logic [DATA_LEN-1:0] data_d [NR_KEY];
  logic [IDX_LEN-1:0]  rr_ptr_q, rr_ptr_d;

  logic                lk_resp_valid_q, lk_resp_valid_d;
  logic                lk_hit_q, lk_hit_d;
  logic [IDX_LEN-1:0]  lk_idx_q, lk_idx_d;
  logic [DATA_LEN-1:0] lk_data_q, lk_data_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full_q, full_d;

  logic [NR_KEY-1:0]   lk_match, upd_match, free_vec;
  logic                lk_found, upd_found, free_found;
  logic [IDX_LEN-1:0]  lk_win, upd_win, free_win;
  upd_kind_t           upd_kind;
  logic [IDX_LEN-1:0]  upd_tgt;

  always_comb begin
    for (int i = 0; i < NR_KEY; i++) begin
      lk_match[i]  = valid_q[i] && (key_q[i] == lk_key);
      upd_match[i] = valid_q[i] && (key_q[i] == upd_key);
      free_vec[i]  = !valid_q[i];
    end
  end

  ysyx_23060096_prio_enc #(.N(NR_KEY), .W(IDX_LEN)) u_lk_enc (
    .req(lk_match), .found(lk_found), .idx(lk_win)
  );
  ysyx_23060096_prio_enc #(.N(NR_KEY), .W(IDX_LEN)) u_upd_enc (
    .req(upd_match), .found(upd_found), .idx(upd_win)
  );
  ysyx_23060096_prio_enc #(.N(NR_KEY), .W(IDX_LEN)) u_free_enc (
    .req(free_vec), .found(free_found), .idx(free_win)
  );

  // Placement is chosen from pre-invalidate state, so a slot freed by a
  // concurrent invalidate is not reused until the next cycle.
  always_comb begin
    upd_kind = UPD_REPLACE;
    upd_tgt  = rr_ptr_q;
    if (upd_found) begin
      upd_kind = UPD_HIT;
      upd_tgt  = upd_win;
    end else if (free_found) begin
      upd_kind = UPD_ALLOC;
      upd_tgt  = free_win;
    end
  end

  // Lookup reads the table as it was before this edge's writes.
  always_comb begin
    lk_resp_valid_d = lk_valid;
    lk_hit_d        = lk_hit_q;
    lk_idx_d        = lk_idx_q;
    lk_data_d       = lk_data_q;
    if (lk_valid) begin
      lk_hit_d = lk_found;
      lk_idx_d = lk_found ? lk_win : '0;
      if (lk_found)             lk_data_d = data_q[lk_win];
      else if (HAS_DEFAULT != 0) lk_data_d = default_out;
      else                      lk_data_d = '0;
    end
  end

  // Invalidate is applied before the update so that an update to the same
  // key leaves the entry valid.
  always_comb begin
    valid_d  = valid_q;
    key_d    = key_q;
    data_d   = data_q;
    rr_ptr_d = rr_ptr_q;
    if (inv_en) begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (key_q[i] == inv_key) valid_d[i] = 1'b0;
      end
    end
    if (upd_en) begin
      valid_d[upd_tgt] = 1'b1;
      data_d[upd_tgt]  = upd_data;
      if (upd_kind != UPD_HIT) key_d[upd_tgt] = upd_key;
      if (upd_kind == UPD_REPLACE) begin
        rr_ptr_d = (rr_ptr_q == IDX_LEN'(NR_KEY - 1)) ? '0 : rr_ptr_q + 1'b1;
      end
    end
    if (flush) begin
      valid_d  = '0;
      rr_ptr_d = '0;
    end
  end

  always_comb begin
    count_d = '0;
    for (int i = 0; i < NR_KEY; i++) count_d = count_d + CNT_W'(valid_d[i]);
    full_d = &valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q         <= '0;
      rr_ptr_q        <= '0;
      lk_resp_valid_q <= 1'b0;
      lk_hit_q        <= 1'b0;
      lk_idx_q        <= '0;
      lk_data_q       <= '0;
      count_q         <= '0;
      full_q          <= 1'b0;
    end else begin
      valid_q         <= valid_d;
      rr_ptr_q        <= rr_ptr_d;
      lk_resp_valid_q <= lk_resp_valid_d;
      lk_hit_q        <= lk_hit_d;
      lk_idx_q        <= lk_idx_d;
      lk_data_q       <= lk_data_d;
      count_q         <= count_d;
      full_q          <= full_d;
    end
  end

  // Key and data storage carries no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    key_q  <= key_d;
    data_q <= data_d;
  end

  assign lk_resp_valid = lk_resp_valid_q;
  assign lk_hit        = lk_hit_q;
  assign lk_idx        = lk_idx_q;
  assign lk_data       = lk_data_q;
  assign count         = count_q;
  assign full          = full_q;

endmodule

// File: tb/tb_ysyx_23060096_key_cam.sv
// tb/tb_ysyx_23060096_key_cam.sv - self-checking bench for ysyx_23060096_key_cam
module tb_ysyx_23060096_key_cam;

  localparam int NR = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lk_valid = 1'b0;
  logic [7:0]  lk_key = '0;
  logic [31:0] default_out = '0;
  logic        lk_resp_valid, lk_hit;
  logic [1:0]  lk_idx;
  logic [31:0] lk_data;
  logic        upd_en = 1'b0;
  logic [7:0]  upd_key = '0;
  logic [31:0] upd_data = '0;
  logic        inv_en = 1'b0;
  logic [7:0]  inv_key = '0;
  logic        flush = 1'b0;
  logic        full;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_23060096_key_cam #(
    .NR_KEY(4), .KEY_LEN(8), .DATA_LEN(32), .HAS_DEFAULT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_key(lk_key), .default_out(default_out),
    .lk_resp_valid(lk_resp_valid), .lk_hit(lk_hit), .lk_idx(lk_idx), .lk_data(lk_data),
    .upd_en(upd_en), .upd_key(upd_key), .upd_data(upd_data),
    .inv_en(inv_en), .inv_key(inv_key), .flush(flush),
    .full(full), .count(count)
  );

  // Reference model: table of entries plus the expected registered outputs.
  logic        m_valid [NR];
  logic [7:0]  m_key   [NR];
  logic [31:0] m_data  [NR];
  int          m_rr;
  logic        e_rv, e_hit, e_full;
  logic [1:0]  e_idx;
  logic [31:0] e_data;
  logic [2:0]  e_count;

  // Drives one cycle of inputs, advances the model, returns #1 after the edge.
  task automatic step(input logic lkv, input logic [7:0] lkk, input logic [31:0] dflt,
                      input logic upd, input logic [7:0] uk, input logic [31:0] ud,
                      input logic inv, input logic [7:0] ik, input logic fl, input logic r);
    int w, tgt, n;
    bool_dummy: begin end
    lk_valid = lkv; lk_key = lkk; default_out = dflt;
    upd_en = upd; upd_key = uk; upd_data = ud;
    inv_en = inv; inv_key = ik; flush = fl; rst = r;
    w = -1;
    for (int i = 0; i < NR; i++) if (w < 0 && m_valid[i] && m_key[i] == lkk) w = i;
    if (r) begin
      for (int i = 0; i < NR; i++) m_valid[i] = 1'b0;
      m_rr = 0; e_rv = 0; e_hit = 0; e_idx = 0; e_data = 0;
    end else begin
      e_rv = lkv;
      if (lkv) begin
        e_hit  = (w >= 0);
        e_idx  = (w >= 0) ? 2'(w) : 2'd0;
        e_data = (w >= 0) ? m_data[w] : dflt;
      end
      if (fl) begin
        for (int i = 0; i < NR; i++) m_valid[i] = 1'b0;
        m_rr = 0;
      end else begin
        tgt = -1;
        for (int i = 0; i < NR; i++) if (tgt < 0 && m_valid[i] && m_key[i] == uk) tgt = i;
        if (tgt < 0) for (int i = 0; i < NR; i++) if (tgt < 0 && !m_valid[i]) tgt = i + 100;
        if (inv) for (int i = 0; i < NR; i++) if (m_key[i] == ik) m_valid[i] = 1'b0;
        if (upd) begin
          if (tgt >= 100) begin
            tgt = tgt - 100;
            m_key[tgt] = uk;
          end else if (tgt < 0) begin
            tgt = m_rr;
            m_key[tgt] = uk;
            m_rr = (m_rr + 1) % NR;
          end
          m_data[tgt] = ud;
          m_valid[tgt] = 1'b1;
        end
      end
    end
    n = 0;
    for (int i = 0; i < NR; i++) n += int'(m_valid[i]);
    e_count = 3'(n);
    e_full  = (n == NR);
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [7:0] k, input logic [31:0] dflt);
    step(1'b1, k, dflt, 1'b0, 8'h0, 32'h0, 1'b0, 8'h0, 1'b0, 1'b0);
  endtask

  task automatic insert(input logic [7:0] k, input logic [31:0] d);
    step(1'b0, 8'h0, 32'h0, 1'b1, k, d, 1'b0, 8'h0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 8'h0, 32'h0, 1'b0, 8'h0, 32'h0, 1'b0, 8'h0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    checks++; if (lk_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got=%0b exp=0", lk_resp_valid); end
    checks++; if (lk_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%0b exp=0", lk_hit); end
    checks++; if (lk_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", lk_idx); end
    checks++; if (lk_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", lk_data); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", full); end
  endtask

  task automatic test_default_miss();
    lookup(8'h12, 32'hDEAD);
    checks++; if (lk_resp_valid !== 1'b1) begin errors++; $display("FAIL miss_rv got=%0b exp=1", lk_resp_valid); end
    checks++; if (lk_hit !== 1'b0) begin errors++; $display("FAIL miss_hit got=%0b exp=0", lk_hit); end
    checks++; if (lk_data !== 32'hDEAD) begin errors++; $display("FAIL miss_data got=%h exp=dead", lk_data); end
    checks++; if (lk_idx !== 2'd0) begin errors++; $display("FAIL miss_idx got=%0d exp=0", lk_idx); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL miss_count got=%0d exp=0", count); end
    step(1'b0, 8'h0, 32'h0, 1'b0, 8'h0, 32'h0, 1'b0, 8'h0, 1'b0, 1'b0);
    checks++; if (lk_resp_valid !== 1'b0 || lk_data !== 32'hDEAD) begin
      errors++; $display("FAIL idle_hold got rv=%0b data=%h exp rv=0 data=dead", lk_resp_valid, lk_data);
    end
  endtask

  task automatic test_insert_full();
    for (int i = 0; i < 4; i++) insert(8'(i + 1), 32'(10 + i));
    lookup(8'h03, 32'h0);
    checks++; if (lk_hit !== 1'b1 || lk_idx !== 2'd2 || lk_data !== 32'hC) begin
      errors++; $display("FAIL fill_lookup got hit=%0b idx=%0d data=%h exp hit=1 idx=2 data=c", lk_hit, lk_idx, lk_data);
    end
    checks++; if (full !== 1'b1 || count !== 3'd4) begin
      errors++; $display("FAIL fill_occupancy got full=%0b count=%0d exp full=1 count=4", full, count);
    end
  endtask

  task automatic test_replace();
    insert(8'h05, 32'hE);
    insert(8'h06, 32'hF);
    lookup(8'h01, 32'h0);
    checks++; if (lk_hit !== 1'b0) begin errors++; $display("FAIL repl_old_key got hit=%0b exp=0", lk_hit); end
    lookup(8'h06, 32'h0);
    checks++; if (lk_hit !== 1'b1 || lk_idx !== 2'd1 || lk_data !== 32'hF) begin
      errors++; $display("FAIL repl_new_key got hit=%0b idx=%0d data=%h exp hit=1 idx=1 data=f", lk_hit, lk_idx, lk_data);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    insert(8'h02, 32'hB);
    step(1'b1, 8'h02, 32'h0, 1'b1, 8'h02, 32'h99, 1'b1, 8'h02, 1'b0, 1'b0);
    checks++; if (lk_hit !== 1'b1 || lk_data !== 32'hB) begin
      errors++; $display("FAIL rbw_old_data got hit=%0b data=%h exp hit=1 data=b", lk_hit, lk_data);
    end
    lookup(8'h02, 32'h0);
    checks++; if (lk_hit !== 1'b1 || lk_data !== 32'h99 || count !== 3'd1) begin
      errors++; $display("FAIL upd_beats_inv got hit=%0b data=%h count=%0d exp hit=1 data=99 count=1", lk_hit, lk_data, count);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) insert(8'(8'h20 + i), 32'(i));
    step(1'b0, 8'h0, 32'h0, 1'b1, 8'h30, 32'h77, 1'b0, 8'h0, 1'b1, 1'b0);
    checks++; if (count !== 3'd0 || full !== 1'b0) begin
      errors++; $display("FAIL flush_empty got count=%0d full=%0b exp count=0 full=0", count, full);
    end
    lookup(8'h30, 32'h0);
    checks++; if (lk_hit !== 1'b0) begin errors++; $display("FAIL flush_upd_dropped got hit=%0b exp=0", lk_hit); end
    for (int i = 0; i < 5; i++) insert(8'(8'h40 + i), 32'(i));
    lookup(8'h44, 32'h0);
    checks++; if (lk_hit !== 1'b1 || lk_idx !== 2'd0) begin
      errors++; $display("FAIL flush_rr_restart got hit=%0b idx=%0d exp hit=1 idx=0", lk_hit, lk_idx);
    end
  endtask

  task automatic test_reset_mid();
    lookup(8'h41, 32'h0);
    do_reset();
    checks++; if (lk_resp_valid !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL midrst got rv=%0b count=%0d exp rv=0 count=0", lk_resp_valid, count);
    end
    for (int k = 0; k < 5; k++) begin
      lookup(8'(8'h40 + k), 32'h5);
      checks++; if (lk_hit !== 1'b0) begin errors++; $display("FAIL midrst_miss key=%0h got hit=%0b exp=0", 8'h40 + k, lk_hit); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 4, 8'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3) == 0, 8'($urandom_range(0, 7)),
           $urandom_range(0, 31) == 0, $urandom_range(0, 99) == 0);
      checks++; if (lk_resp_valid !== e_rv || lk_hit !== e_hit || lk_idx !== e_idx || lk_data !== e_data) begin
        errors++; $display("FAIL rand_resp cyc=%0d got rv=%0b hit=%0b idx=%0d data=%h exp rv=%0b hit=%0b idx=%0d data=%h",
                           n, lk_resp_valid, lk_hit, lk_idx, lk_data, e_rv, e_hit, e_idx, e_data);
      end
      checks++; if (count !== e_count || full !== e_full) begin
        errors++; $display("FAIL rand_occ cyc=%0d got count=%0d full=%0b exp count=%0d full=%0b", n, count, full, e_count, e_full);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin m_valid[i] = 1'b0; m_key[i] = '0; m_data[i] = '0; end
    m_rr = 0;
    test_reset();
    test_default_miss();
    test_insert_full();
    test_replace();
    test_same_cycle();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
